la_capture_seq: RTL and testbench

//  Acquisition sequencer for the logic-analyser capture path. Arms sampling by driving the

---
 rtl/la_capture_seq.sv | 157 +++++++++++++++
 tb/tb_la_capture_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_seq.sv
`default_nettype none
// ============================================================================
// Module      : la_capture_seq
// Description : Logic-analyser acquisition sequencer. Arms the sampler, then
//               streams the circular capture RAM oldest-first via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module la_capture_seq #(
    parameter int CHN_NUM = 8,
    parameter int ADDR_W  = 10
) (
    input  logic               iSysClk,
    input  logic               iRst,
    input  logic               arm,
    input  logic               abort,
    input  logic               cont_mode,
    input  logic               finished_in,
    input  logic [ADDR_W-1:0]  start_addr_in,
    output logic               trigger_en_o,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [CHN_NUM-1:0] rd_data,
    output logic [CHN_NUM-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic [1:0]         state_o,
    output logic [15:0]        frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_trigger_en;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W:0]    r_rd_idx;
    logic               r_inflight;
    logic               r_inflight_last;
    logic [CHN_NUM:0]   r_fifo_word [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_fifo_cnt;
    logic [15:0]        r_frame_cnt;

    logic               w_fifo_empty;
    logic [CHN_NUM:0]   w_head;
    logic               w_pop;
    logic               w_bypass;
    logic               w_push;
    logic               w_fifo_pop;
    logic [1:0]         w_occ_after;
    logic               w_last_accept;

    // An empty FIFO presents the returning RAM word directly, saving a cycle
    // of first-word latency; a stalled bypass word is captured next edge.
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    assign w_head       = r_fifo_word[r_rd_ptr];
    assign out_valid    = !w_fifo_empty || r_inflight;
    assign out_data     = !w_fifo_empty ? w_head[CHN_NUM-1:0]
                        : (r_inflight ? rd_data : '0);
    assign out_last     = !w_fifo_empty ? w_head[CHN_NUM] : (r_inflight & r_inflight_last);

    assign w_pop        = out_valid & out_ready;
    assign w_bypass     = w_fifo_empty & r_inflight & out_ready;
    assign w_push       = r_inflight & ~w_bypass;
    assign w_fifo_pop   = w_pop & ~w_fifo_empty;

    // Credit counts the beat leaving this cycle so back-to-back reads sustain full rate.
    assign w_occ_after  = r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign rd_en        = (r_state == ST_READOUT) && !r_rd_idx[ADDR_W]
                        && (w_occ_after < 2'd2) && !abort;
    assign rd_addr      = r_base + r_rd_idx[ADDR_W-1:0];

    assign w_last_accept = (r_state == ST_READOUT) && w_pop && out_last;

    assign trigger_en_o = r_trigger_en;
    assign busy         = (r_state != ST_IDLE);
    assign state_o      = r_state;
    assign frame_cnt    = r_frame_cnt;

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (arm)         w_state_nxt = ST_ARMED;
                ST_ARMED:   if (finished_in) w_state_nxt = ST_LATCH;
                ST_LATCH:                    w_state_nxt = ST_READOUT;
                ST_READOUT: if (w_last_accept)
                                w_state_nxt = cont_mode ? ST_ARMED : ST_IDLE;
                default:                     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iSysClk or negedge iRst) begin
        if (!iRst) begin
            r_state         <= ST_IDLE;
            r_trigger_en    <= 1'b0;
            r_base          <= '0;
            r_rd_idx        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_word[0]  <= '0;
            r_fifo_word[1]  <= '0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_fifo_cnt      <= 2'd0;
            r_frame_cnt     <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_trigger_en <= (w_state_nxt == ST_ARMED);

            if (r_state == ST_LATCH) begin
                r_base <= start_addr_in;
            end

            if (abort || (r_state == ST_LATCH)) begin
                r_rd_idx <= '0;
            end else if (rd_en) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end

            r_inflight      <= rd_en;
            r_inflight_last <= (r_rd_idx[ADDR_W-1:0] == '1);

            if (abort) begin
                r_fifo_cnt <= 2'd0;
                r_wr_ptr   <= 1'b0;
                r_rd_ptr   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_fifo_word[r_wr_ptr] <= {r_inflight_last, rd_data};
                    r_wr_ptr              <= ~r_wr_ptr;
                end
                if (w_fifo_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_fifo_pop};
            end

            if (!abort && w_last_accept) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_la_capture_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_la_capture_seq
// Description : Randomised self-checking bench for la_capture_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_la_capture_seq;
    localparam int CHN_NUM = 8;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    logic               iSysClk = 1'b0;
    logic               iRst;
    logic               arm;
    logic               abort;
    logic               cont_mode;
    logic               finished_in;
    logic [ADDR_W-1:0]  start_addr_in;
    logic               trigger_en_o;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [CHN_NUM-1:0] rd_data;
    logic [CHN_NUM-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic [1:0]         state_o;
    logic [15:0]        frame_cnt;

    la_capture_seq #(.CHN_NUM(CHN_NUM), .ADDR_W(ADDR_W)) dut (
        .iSysClk(iSysClk), .iRst(iRst), .arm(arm), .abort(abort),
        .cont_mode(cont_mode), .finished_in(finished_in),
        .start_addr_in(start_addr_in), .trigger_en_o(trigger_en_o),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .state_o(state_o), .frame_cnt(frame_cnt)
    );

    always #5 iSysClk = ~iSysClk;

    // Capture RAM: one-cycle read latency, garbage when not read.
    logic [CHN_NUM-1:0] ram [DEPTH];
    always @(posedge iSysClk) rd_data <= rd_en ? ram[rd_addr] : CHN_NUM'($urandom);

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model of the sequencer
    logic [1:0]         m_phase;
    logic [ADDR_W-1:0]  m_base;
    int                 m_rdcnt, m_idx, m_frames, m_lat;
    int                 m_beats, m_last_cnt, m_last_at;
    logic [ADDR_W-1:0]  m_addr0, m_addr16;
    logic               p_stall;
    logic [CHN_NUM-1:0] p_data;
    logic               p_last;
    int                 rdy_mode;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = S_IDLE; m_base = '0; m_rdcnt = 0; m_idx = 0; m_frames = 0;
        m_lat = -1; m_beats = 0; m_last_cnt = 0; m_last_at = -1;
        m_addr0 = '0; m_addr16 = '0; p_stall = 1'b0; p_data = '0; p_last = 1'b0;
    endtask

    task automatic cycle_check();
        logic acc;
        if (!iRst) begin
            model_reset();
            return;
        end
        if (m_lat >= 0) begin
            m_lat++;
            if (m_lat == 3) begin
                if (m_phase == S_READ) chk("first_valid_latency", out_valid, 1);
                m_lat = -1;
            end
        end
        chk("state", state_o, m_phase);
        chk("busy", busy, m_phase != S_IDLE);
        chk("trigger_en", trigger_en_o, m_phase == S_ARMED);
        chk("frame_cnt", frame_cnt, m_frames % 65536);
        chk("occupancy_le_2", (m_rdcnt - m_idx) <= 2, 1);
        if (m_phase != S_READ) begin
            chk("rd_en_outside_readout", rd_en, 0);
            chk("out_valid_outside_readout", out_valid, 0);
        end
        if (rd_en && m_phase == S_READ) begin
            chk("rd_count_bound", m_rdcnt < DEPTH, 1);
            chk("rd_addr", rd_addr, (int'(m_base) + m_rdcnt) % DEPTH);
            if (m_rdcnt == 0)  m_addr0  = rd_addr;
            if (m_rdcnt == 16) m_addr16 = rd_addr;
            m_rdcnt++;
        end
        if (p_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, p_data);
            chk("stall_last", out_last, p_last);
        end
        acc = out_valid && out_ready;
        if (acc && m_phase == S_READ) begin
            chk("out_data", out_data, ram[(int'(m_base) + m_idx) % DEPTH]);
            chk("out_last", out_last, m_idx == DEPTH - 1);
            if (out_last) begin
                m_last_cnt++;
                m_last_at = m_idx;
            end
            m_idx++;
            m_beats++;
        end
        p_stall = out_valid && !out_ready && !abort;
        p_data  = out_data;
        p_last  = out_last;
        if (abort) begin
            m_phase = S_IDLE; m_lat = -1; m_rdcnt = 0; m_idx = 0;
        end else begin
            case (m_phase)
                S_IDLE:  if (arm) m_phase = S_ARMED;
                S_ARMED: if (finished_in) begin m_phase = S_LATCH; m_lat = 0; end
                S_LATCH: begin
                    m_base = start_addr_in; m_rdcnt = 0; m_idx = 0; m_beats = 0;
                    m_last_cnt = 0; m_last_at = -1; m_phase = S_READ;
                end
                S_READ:  if (m_idx == DEPTH) begin
                    m_frames++;
                    m_phase = cont_mode ? S_ARMED : S_IDLE;
                end
                default: m_phase = S_IDLE;
            endcase
        end
    endtask

    // One cycle: compare at the falling edge, then drive fresh inputs after the rising edge.
    task automatic tick();
        @(negedge iSysClk);
        cycle_check();
        @(posedge iSysClk);
        #1;
        arm = 1'b0; abort = 1'b0; finished_in = 1'b0;
        start_addr_in = ADDR_W'($urandom);
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic run_frame(input bit do_arm, input int delay, input logic [ADDR_W-1:0] addr);
        if (do_arm) begin arm = 1'b1; tick(); end
        repeat (delay) tick();
        finished_in = 1'b1; tick();
        start_addr_in = addr; tick();
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (m_frames < target && n < 4000) begin tick(); n++; end
        chk("frame_timeout", m_frames, target);
    endtask

    initial begin
        int n;
        iRst = 1'b0; arm = 1'b0; abort = 1'b0; cont_mode = 1'b0; finished_in = 1'b0;
        start_addr_in = '0; out_ready = 1'b0; rdy_mode = 0;
        for (int i = 0; i < DEPTH; i++) ram[i] = CHN_NUM'($urandom);
        model_reset();
        repeat (3) tick();
        chk("rst_state", state_o, 0);
        chk("rst_trigger", trigger_en_o, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        iRst = 1'b1;

        // Single-shot frame, wrapping start address, full-rate sink
        rdy_mode = 1; out_ready = 1'b1;
        run_frame(1'b1, 50, 10'h3F0);
        wait_frames(1);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_state", state_o, 0);
        chk("t1_beats", m_beats, 1024);
        chk("t1_last_count", m_last_cnt, 1);
        chk("t1_last_index", m_last_at, 1023);
        chk("t1_first_addr", m_addr0, 10'h3F0);
        chk("t1_wrap_addr", m_addr16, 10'h000);

        // Randomly stalling sink
        rdy_mode = 2;
        run_frame(1'b1, $urandom_range(5, 40), ADDR_W'($urandom));
        wait_frames(2);
        chk("t2_frame_cnt", frame_cnt, 2);
        chk("t2_beats", m_beats, 1024);
        chk("t2_last_count", m_last_cnt, 1);
        rdy_mode = 1;

        // Continuous re-arm
        cont_mode = 1'b1;
        run_frame(1'b1, 20, 10'h155);
        wait_frames(3);
        chk("t3_rearm_trigger", trigger_en_o, 1);
        chk("t3_rearm_state", state_o, 1);
        cont_mode = 1'b0;
        run_frame(1'b0, 30, 10'h2AA);
        wait_frames(4);
        chk("t3_frame_cnt", frame_cnt, 4);
        chk("t3_state", state_o, 0);

        // Abort mid-readout while stalled, then a clean frame
        run_frame(1'b1, 10, 10'h000);
        n = 0;
        while (m_idx < 500 && n < 2000) begin tick(); n++; end
        rdy_mode = 0; out_ready = 1'b0;
        repeat (4) tick();
        abort = 1'b1; tick();
        chk("t4_out_valid", out_valid, 0);
        chk("t4_rd_en", rd_en, 0);
        chk("t4_state", state_o, 0);
        chk("t4_trigger", trigger_en_o, 0);
        chk("t4_frame_cnt", frame_cnt, 4);
        rdy_mode = 1; out_ready = 1'b1;
        run_frame(1'b1, 15, 10'h3FF);
        wait_frames(5);
        chk("t4_frame_cnt_after", frame_cnt, 5);
        chk("t4_beats", m_beats, 1024);
        chk("t4_last_index", m_last_at, 1023);

        // Ignored inputs and arm/abort collision
        run_frame(1'b1, 5, 10'h0AB);
        repeat (100) tick();
        arm = 1'b1; tick();
        wait_frames(6);
        chk("t5_frame_cnt", frame_cnt, 6);
        finished_in = 1'b1; tick(); tick();
        chk("t5_finished_ignored", state_o, 0);
        arm = 1'b1; abort = 1'b1; tick(); tick();
        chk("t5_arm_abort_state", state_o, 0);
        chk("t5_arm_abort_trigger", trigger_en_o, 0);

        // Asynchronous reset mid-readout
        run_frame(1'b1, 5, 10'h123);
        repeat (200) tick();
        #2 iRst = 1'b0;
        #1;
        chk("t6_state", state_o, 0);
        chk("t6_trigger", trigger_en_o, 0);
        chk("t6_rd_en", rd_en, 0);
        chk("t6_rd_addr", rd_addr, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_out_last", out_last, 0);
        chk("t6_busy", busy, 0);
        chk("t6_frame_cnt", frame_cnt, 0);
        repeat (2) tick();
        iRst = 1'b1;
        tick();
        run_frame(1'b1, 5, 10'h200);
        wait_frames(1);
        chk("t6_frame_after_reset", frame_cnt, 1);
        chk("t6_beats_after_reset", m_beats, 1024);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
